neopixel_frame_sequencer: RTL

//  Sequences one WS2812 frame: fetches NUM_LEDS 24-bit GRB words from a pixel source over
//  a req/valid handshake, serialises them MSB-first on dout, then holds the latch gap.

---
 rtl/neopixel_frame_sequencer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/neopixel_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : neopixel_frame_sequencer
// Brief    : Fetches NUM_LEDS GRB words over req/valid, serialises them as
//            WS2812 bits with one-deep prefetch, then holds the latch gap.
// Revision : 1.0
// ============================================================================
module neopixel_frame_sequencer #(
    parameter int NUM_LEDS  = 64,
    parameter int ADDR_W    = 6,
    parameter int T_BIT     = 25,
    parameter int T0H       = 8,
    parameter int T1H       = 16,
    parameter int RESET_CYC = 1200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun,
    output logic              pix_req,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic              pix_valid,
    input  logic [23:0]       pix_grb,
    output logic              dout
);

    localparam int c_cyc_w = $clog2(T_BIT);
    localparam int c_lat_w = $clog2(RESET_CYC + 1);

    localparam logic [c_cyc_w-1:0] c_cyc_last = c_cyc_w'(T_BIT - 1);
    localparam logic [c_cyc_w-1:0] c_t0h      = c_cyc_w'(T0H);
    localparam logic [c_cyc_w-1:0] c_t1h      = c_cyc_w'(T1H);
    localparam logic [c_lat_w-1:0] c_lat_last = c_lat_w'(RESET_CYC - 1);
    localparam logic [ADDR_W-1:0]  c_led_last = ADDR_W'(NUM_LEDS - 1);
    localparam logic [4:0]         c_bit_last = 5'd23;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SEND  = 3'd2,
        S_STALL = 3'd3,
        S_LATCH = 3'd4
    } state_t;

    state_t              r_state,       w_state_nxt;
    logic [c_cyc_w-1:0]  r_cyc,         w_cyc_nxt;
    logic [4:0]          r_bit,         w_bit_nxt;
    logic [23:0]         r_shift,       w_shift_nxt;
    logic [23:0]         r_shadow,      w_shadow_nxt;
    logic                r_shadow_full, w_shadow_full_nxt;
    logic [ADDR_W-1:0]   r_led,         w_led_nxt;
    logic                r_pix_req,     w_pix_req_nxt;
    logic [ADDR_W-1:0]   r_pix_addr,    w_pix_addr_nxt;
    logic [c_lat_w-1:0]  r_lat,         w_lat_nxt;
    logic                r_pending,     w_pending_nxt;
    logic                r_underrun,    w_underrun_nxt;
    logic                r_dout,        w_dout_nxt;
    logic                w_xfer;
    logic                w_enter_send;

    always_comb begin
        w_state_nxt       = r_state;
        w_cyc_nxt         = r_cyc;
        w_bit_nxt         = r_bit;
        w_shift_nxt       = r_shift;
        w_shadow_nxt      = r_shadow;
        w_shadow_full_nxt = r_shadow_full;
        w_led_nxt         = r_led;
        w_pix_req_nxt     = r_pix_req;
        w_pix_addr_nxt    = r_pix_addr;
        w_lat_nxt         = r_lat;
        w_pending_nxt     = r_pending;
        w_underrun_nxt    = r_underrun;
        w_enter_send      = 1'b0;
        w_xfer            = r_pix_req & pix_valid;

        if (frame_start && (r_state != S_IDLE)) begin
            w_pending_nxt = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (frame_start || r_pending) begin
                    w_pending_nxt     = 1'b0;
                    w_state_nxt       = S_FETCH;
                    w_pix_req_nxt     = 1'b1;
                    w_pix_addr_nxt    = '0;
                    w_led_nxt         = '0;
                    w_shadow_full_nxt = 1'b0;
                end
            end
            S_FETCH: begin
                if (w_xfer) begin
                    w_shift_nxt  = pix_grb;
                    w_state_nxt  = S_SEND;
                    w_cyc_nxt    = '0;
                    w_bit_nxt    = '0;
                    w_enter_send = 1'b1;
                end
            end
            S_SEND: begin
                if (w_xfer) begin
                    w_shadow_nxt      = pix_grb;
                    w_shadow_full_nxt = 1'b1;
                    w_pix_req_nxt     = 1'b0;
                end
                if (r_cyc != c_cyc_last) begin
                    w_cyc_nxt = r_cyc + 1'b1;
                end else begin
                    w_cyc_nxt   = '0;
                    w_shift_nxt = {r_shift[22:0], 1'b0};
                    if (r_bit != c_bit_last) begin
                        w_bit_nxt = r_bit + 1'b1;
                    end else begin
                        w_bit_nxt = '0;
                        if (r_led == c_led_last) begin
                            w_state_nxt = S_LATCH;
                            w_lat_nxt   = '0;
                        end else if (r_shadow_full || w_xfer) begin
                            // A word arriving on the very last cycle bypasses the shadow.
                            w_shift_nxt       = r_shadow_full ? r_shadow : pix_grb;
                            w_shadow_full_nxt = 1'b0;
                            w_led_nxt         = r_led + 1'b1;
                            w_enter_send      = 1'b1;
                        end else begin
                            w_state_nxt    = S_STALL;
                            w_underrun_nxt = 1'b1;
                        end
                    end
                end
            end
            S_STALL: begin
                if (w_xfer) begin
                    w_shift_nxt  = pix_grb;
                    w_led_nxt    = r_led + 1'b1;
                    w_state_nxt  = S_SEND;
                    w_cyc_nxt    = '0;
                    w_bit_nxt    = '0;
                    w_enter_send = 1'b1;
                end
            end
            S_LATCH: begin
                if (r_lat == c_lat_last) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_lat_nxt = r_lat + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Every new LED immediately requests its successor.
        if (w_enter_send) begin
            if (w_led_nxt != c_led_last) begin
                w_pix_req_nxt  = 1'b1;
                w_pix_addr_nxt = w_led_nxt + 1'b1;
            end else begin
                w_pix_req_nxt = 1'b0;
            end
        end

        w_dout_nxt = (w_state_nxt == S_SEND) &&
                     (w_cyc_nxt < (w_shift_nxt[23] ? c_t1h : c_t0h));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cyc         <= '0;
            r_bit         <= '0;
            r_shift       <= '0;
            r_shadow      <= '0;
            r_shadow_full <= 1'b0;
            r_led         <= '0;
            r_pix_req     <= 1'b0;
            r_pix_addr    <= '0;
            r_lat         <= '0;
            r_pending     <= 1'b0;
            r_underrun    <= 1'b0;
            r_dout        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cyc         <= w_cyc_nxt;
            r_bit         <= w_bit_nxt;
            r_shift       <= w_shift_nxt;
            r_shadow      <= w_shadow_nxt;
            r_shadow_full <= w_shadow_full_nxt;
            r_led         <= w_led_nxt;
            r_pix_req     <= w_pix_req_nxt;
            r_pix_addr    <= w_pix_addr_nxt;
            r_lat         <= w_lat_nxt;
            r_pending     <= w_pending_nxt;
            r_underrun    <= w_underrun_nxt;
            r_dout        <= w_dout_nxt;
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign frame_done = (r_state == S_LATCH) && (r_lat == c_lat_last);
    assign underrun   = r_underrun;
    assign pix_req    = r_pix_req;
    assign pix_addr   = r_pix_addr;
    assign dout       = r_dout;

endmodule
`default_nettype wire
